// File: rtl/uart_loader.sv
// UART boot loader: parses A5 / 16-bit length / little-endian word frames from a
// received byte stream, writes the words to instruction memory and then releases the CPU.
module uart_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst_n
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam longint unsigned MAX_WORDS = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [1:0]            r_bcnt;
  logic [23:0]           r_word;
  logic [TW-1:0]         r_tmo;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_cpu_rst_n;

  logic [15:0]           w_len_full;
  logic                  w_tmo_hit;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_len_full = {rx_data, r_len[7:0]};
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
  // r_len is bounded by the length check, so N-1 always fits the index width
  assign w_last     = (r_index == ADDR_WIDTH'(r_len - 16'd1));
  assign w_addr     = ADDR_WIDTH'(BASE_ADDR) + r_index;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_SYNC;
      r_len       <= '0;
      r_index     <= '0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_tmo       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_we <= 1'b0;

      // Inter-byte idle counter; only runs while a frame is open
      if (rx_valid || !r_busy) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      case (r_state)
        S_SYNC: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            r_state <= S_LEN0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_index <= '0;
            r_bcnt  <= '0;
          end
        end
        S_LEN0: begin
          if (rx_valid) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (rx_valid) begin
            r_len[15:8] <= rx_data;
            if (w_len_full == 16'd0) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else if (64'(w_len_full) > MAX_WORDS) begin
              r_state <= S_SYNC;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_we) begin
            r_index <= r_index + ADDR_WIDTH'(1);
            if (w_last) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end
          end
          // A byte landing in the write cycle belongs to the next word
          if (rx_valid && !(r_we && w_last)) begin
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= w_addr;
              r_wdata <= {rx_data, r_word};
            end else begin
              r_word[{r_bcnt, 3'b000} +: 8] <= rx_data;
            end
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= S_SYNC;
          r_busy  <= 1'b0;
        end
      endcase

      // Idle too long inside a frame: drop the partial word and resynchronise
      if (r_busy && !rx_valid && w_tmo_hit) begin
        r_state <= S_SYNC;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
        r_tmo   <= '0;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cpu_rst_n = r_cpu_rst_n;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed frames plus randomized loads checked against an image model.
module tb_uart_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 50;
  localparam int unsigned MAXN = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_rst_n;

  uart_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t         mon_q[$];
  wr_t         exp_q[$];
  logic [31:0] img[$];
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor; a strobe must never last two cycles
  always @(negedge clk) begin
    if (mem_we) begin
      check("we_single_cycle", 64'(prev_we), 64'(0));
      mon_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int stamp);
    rx_valid = 1'b1;
    rx_data  = b;
    stamp    = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Sends a frame for img; legal lengths enqueue the expected writes
  task automatic send_frame(input logic [15:0] n, input int maxgap);
    int st;
    logic [31:0] w;
    send_byte(8'hA5, $urandom_range(0, maxgap), st);
    send_byte(n[7:0], $urandom_range(0, maxgap), st);
    send_byte(n[15:8], $urandom_range(0, maxgap), st);
    if (int'(n) <= MAXN) begin
      for (int i = 0; i < int'(n); i++) begin
        w = img[i];
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8], $urandom_range(0, maxgap), st);
          if (k == 3) exp_q.push_back('{addr: AW'(i), data: w, cyc: st + 1});
        end
      end
    end
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic e_busy, input logic e_done, input logic e_err);
    check({tag, "_busy"}, 64'(busy), 64'(e_busy));
    check({tag, "_done"}, 64'(done), 64'(e_done));
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(e_done));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(mon_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_wr_data"}, 64'(mon_q[i].data), 64'(exp_q[i].data));
      check({tag, "_wr_latency"}, 64'(mon_q[i].cyc), 64'(exp_q[i].cyc));
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int st;
    int n;
    logic [7:0] g;

    // Reset state
    do_reset();
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check_status("rst", 1'b0, 1'b0, 1'b0);

    // Two-word load, then trailing bytes must be ignored in DONE
    img.delete();
    img.push_back(32'h12345678);
    img.push_back(32'hDEADBEEF);
    send_frame(16'd2, 0);
    repeat (3) @(negedge clk);
    check_writes("two_word");
    check_status("two_word", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h00, 0, st);
    for (int k = 0; k < 4; k++) send_byte(8'h5A, 0, st);
    repeat (3) @(negedge clk);
    check_writes("after_done");
    check_status("after_done", 1'b0, 1'b1, 1'b0);

    // Leading garbage and a zero-length image
    do_reset();
    send_byte(8'h00, 0, st);
    send_byte(8'hFF, 0, st);
    send_byte(8'hA5, 0, st);
    send_byte(8'h00, 0, st);
    check_status("zero_len_hdr", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 0, st);
    check_status("zero_len", 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_writes("zero_len");

    // Oversize length (17 > 16 words) then recovery
    do_reset();
    send_byte(8'hA5, 0, st);
    send_byte(8'h11, 0, st);
    send_byte(8'h00, 0, st);
    repeat (2) @(negedge clk);
    check_status("oversize", 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 0, st);
    check_status("err_clear", 1'b1, 1'b0, 1'b0);
    fill_img(1);
    exp_q.push_back('{addr: AW'(0), data: img[0], cyc: 0});
    send_byte(8'h01, 0, st);
    send_byte(8'h00, 0, st);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = img[0];
      send_byte(w[8*k +: 8], 1, st);
    end
    exp_q[0].cyc = st + 1;
    repeat (3) @(negedge clk);
    check_writes("recover");
    check_status("recover", 1'b0, 1'b1, 1'b0);

    // Exactly-full image (16 words) is legal
    do_reset();
    fill_img(MAXN);
    send_frame(16'(MAXN), 1);
    repeat (3) @(negedge clk);
    check_writes("full_image");
    check_status("full_image", 1'b0, 1'b1, 1'b0);

    // Inter-byte timeout fires on the TMO-th idle cycle
    do_reset();
    send_byte(8'hA5, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h00, 0, st);
    send_byte(8'h11, 0, st);
    send_byte(8'h22, 0, st);
    repeat (TMO - 1) @(negedge clk);
    check_status("tmo_before", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_status("tmo_fire", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_writes("tmo_nowrite");
    fill_img(2);
    send_frame(16'd2, 2);
    repeat (3) @(negedge clk);
    check_writes("tmo_recover");
    check_status("tmo_recover", 1'b0, 1'b1, 1'b0);

    // Byte arriving on the would-be timeout cycle wins
    do_reset();
    fill_img(1);
    send_byte(8'hA5, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h00, TMO - 1, st);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = img[0];
      send_byte(w[8*k +: 8], 0, st);
    end
    exp_q.push_back('{addr: AW'(0), data: img[0], cyc: st + 1});
    repeat (3) @(negedge clk);
    check_writes("tmo_race");
    check_status("tmo_race", 1'b0, 1'b1, 1'b0);

    // Back-to-back three-word frame
    do_reset();
    fill_img(3);
    send_frame(16'd3, 0);
    repeat (3) @(negedge clk);
    check_writes("b2b");
    check_status("b2b", 1'b0, 1'b1, 1'b0);

    // Reset mid-word abandons the frame
    do_reset();
    send_byte(8'hA5, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h00, 0, st);
    send_byte(8'h11, 0, st);
    send_byte(8'h22, 0, st);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_we", 64'(mem_we), 64'(0));
    check("midrst_addr", 64'(mem_addr), 64'(0));
    check("midrst_wdata", 64'(mem_wdata), 64'(0));
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    send_byte(8'h33, 0, st);
    send_byte(8'h44, 0, st);
    repeat (5) @(negedge clk);
    check_writes("midrst");
    check_status("midrst_after", 1'b0, 1'b0, 1'b0);

    // Randomized loads with garbage prefixes and gaps
    for (int it = 0; it < 10; it++) begin
      do_reset();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2), st);
      end
      n = $urandom_range(0, MAXN + 4);
      fill_img(n);
      send_frame(16'(n), 3);
      repeat (4) @(negedge clk);
      check_writes("rand");
      if (n > int'(MAXN)) check_status("rand_over", 1'b0, 1'b0, 1'b1);
      else check_status("rand_ok", 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
